// File: rtl/sata_crc_if.sv
// Streaming dword handshake bundle for sata_crc_engine: s_* is the FIS input side,
// m_* is the output toward the scrambler.
interface sata_crc_if #(
  parameter int unsigned DATA_W = 32
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_sof;
  logic              s_eof;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_eof;

  modport slave (
    input  s_valid, s_data, s_sof, s_eof, m_ready,
    output s_ready, m_valid, m_data, m_eof
  );

  modport master (
    output s_valid, s_data, s_sof, s_eof, m_ready,
    input  s_ready, m_valid, m_data, m_eof
  );
endinterface

// File: rtl/sata_crc_engine.sv
// Streaming dword CRC: TX appends the frame CRC after the last dword, RX checks the
// trailing dword against the CRC of the preceding dwords. Registered output stage.
module sata_crc_engine #(
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] CRC_INIT = DATA_W'(32'h52325032),
  parameter logic [DATA_W-1:0] CRC_POLY = DATA_W'(32'h04C11DB7),
  parameter bit                RX_STRIP = 1'b0
) (
  input  logic              clk_75m,
  input  logic              sys_rst,
  input  logic              mode_rx,
  sata_crc_if.slave         bus,
  output logic [DATA_W-1:0] crc_out,
  output logic              crc_done,
  output logic              crc_err,
  output logic              frame_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_APPEND} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] crc_q, crc_d;
  logic              mode_q, mode_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_eof_q, m_eof_d;
  logic              hold_v_q, hold_v_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              crc_done_q, crc_done_d;
  logic              crc_err_q, crc_err_d;
  logic              frame_err_q, frame_err_d;
  logic              out_free;
  logic              s_ready_int;
  logic              accept;

  // One dword folded through the LFSR: 32 zero-input shifts of (data ^ seed).
  function automatic logic [DATA_W-1:0] crc_fold(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    r = x;
    for (int i = 0; i < int'(DATA_W); i++) begin
      r = r[DATA_W-1] ? ((r << 1) ^ CRC_POLY) : (r << 1);
    end
    return r;
  endfunction

  assign out_free    = !m_valid_q || bus.m_ready;
  assign s_ready_int = !sys_rst && (state_q != ST_APPEND) && out_free;
  assign accept      = bus.s_valid && s_ready_int;

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    mode_d      = mode_q;
    m_valid_d   = m_valid_q && !bus.m_ready;
    m_data_d    = m_data_q;
    m_eof_d     = m_eof_q;
    hold_v_d    = hold_v_q;
    hold_data_d = hold_data_q;
    crc_done_d  = 1'b0;
    crc_err_d   = 1'b0;
    frame_err_d = 1'b0;

    if (state_q == ST_APPEND) begin
      if (out_free) begin
        m_valid_d = 1'b1;
        m_data_d  = crc_q;
        m_eof_d   = 1'b1;
        crc_d     = CRC_INIT;
        state_d   = ST_IDLE;
      end
    end else if (accept) begin
      if (bus.s_sof) begin
        // SOF in DATA restarts the frame; the abandoned frame gets no CRC.
        frame_err_d = (state_q == ST_DATA);
        mode_d      = mode_rx;
        hold_v_d    = 1'b0;
        if (mode_rx && bus.s_eof) begin
          crc_done_d = 1'b1;
          crc_err_d  = (bus.s_data != CRC_INIT);
          crc_d      = CRC_INIT;
          state_d    = ST_IDLE;
          if (!RX_STRIP) begin
            m_valid_d = 1'b1;
            m_data_d  = bus.s_data;
            m_eof_d   = 1'b1;
          end
        end else begin
          crc_d   = crc_fold(bus.s_data ^ CRC_INIT);
          state_d = bus.s_eof ? ST_APPEND : ST_DATA;
          if (mode_rx && RX_STRIP) begin
            hold_v_d    = 1'b1;
            hold_data_d = bus.s_data;
          end else begin
            m_valid_d = 1'b1;
            m_data_d  = bus.s_data;
            m_eof_d   = 1'b0;
          end
        end
      end else if (state_q == ST_IDLE) begin
        frame_err_d = 1'b1;
      end else if (mode_q && bus.s_eof) begin
        crc_done_d = 1'b1;
        crc_err_d  = (bus.s_data != crc_q);
        state_d    = ST_IDLE;
        if (RX_STRIP) begin
          // Stripped CRC: the held dword becomes the frame's last output.
          hold_v_d = 1'b0;
          if (hold_v_q) begin
            m_valid_d = 1'b1;
            m_data_d  = hold_data_q;
            m_eof_d   = 1'b1;
          end
        end else begin
          m_valid_d = 1'b1;
          m_data_d  = bus.s_data;
          m_eof_d   = 1'b1;
        end
      end else begin
        crc_d   = crc_fold(bus.s_data ^ crc_q);
        state_d = (!mode_q && bus.s_eof) ? ST_APPEND : ST_DATA;
        if (mode_q && RX_STRIP) begin
          hold_v_d    = 1'b1;
          hold_data_d = bus.s_data;
          if (hold_v_q) begin
            m_valid_d = 1'b1;
            m_data_d  = hold_data_q;
            m_eof_d   = 1'b0;
          end
        end else begin
          m_valid_d = 1'b1;
          m_data_d  = bus.s_data;
          m_eof_d   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_75m or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      crc_q       <= CRC_INIT;
      mode_q      <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_eof_q     <= 1'b0;
      hold_v_q    <= 1'b0;
      hold_data_q <= '0;
      crc_done_q  <= 1'b0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      mode_q      <= mode_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_eof_q     <= m_eof_d;
      hold_v_q    <= hold_v_d;
      hold_data_q <= hold_data_d;
      crc_done_q  <= crc_done_d;
      crc_err_q   <= crc_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.s_ready = s_ready_int;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_eof   = m_eof_q;
  assign crc_out     = crc_q;
  assign crc_done    = crc_done_q;
  assign crc_err     = crc_err_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_sata_crc_engine.sv
// Directed bench for sata_crc_engine: vector table of short TX/RX frames plus
// hand-written stall, protocol-error, async-reset and RX_STRIP sequences.
module tb_sata_crc_engine;

  localparam logic [31:0] INIT = 32'h52325032;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic        clk_75m = 1'b0;
  logic        sys_rst = 1'b1;
  logic        mode_rx = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_sof   = 1'b0;
  logic        s_eof   = 1'b0;
  logic [31:0] s_data  = '0;
  logic        m_ready = 1'b1;
  logic        sel     = 1'b0;
  logic        rnd_en  = 1'b0;

  always #5 clk_75m = ~clk_75m;

  sata_crc_if #(.DATA_W(32)) ifa ();
  sata_crc_if #(.DATA_W(32)) ifb ();

  assign ifa.s_valid = s_valid && !sel;
  assign ifa.s_data  = s_data;
  assign ifa.s_sof   = s_sof;
  assign ifa.s_eof   = s_eof;
  assign ifa.m_ready = m_ready;
  assign ifb.s_valid = s_valid && sel;
  assign ifb.s_data  = s_data;
  assign ifb.s_sof   = s_sof;
  assign ifb.s_eof   = s_eof;
  assign ifb.m_ready = m_ready;

  logic [31:0] a_crc, b_crc;
  logic        a_done, a_err, a_ferr, b_done, b_err, b_ferr;

  sata_crc_engine #(.DATA_W(32), .RX_STRIP(1'b0)) dut_a (
    .clk_75m(clk_75m), .sys_rst(sys_rst), .mode_rx(mode_rx), .bus(ifa.slave),
    .crc_out(a_crc), .crc_done(a_done), .crc_err(a_err), .frame_err(a_ferr));

  sata_crc_engine #(.DATA_W(32), .RX_STRIP(1'b1)) dut_b (
    .clk_75m(clk_75m), .sys_rst(sys_rst), .mode_rx(mode_rx), .bus(ifb.slave),
    .crc_out(b_crc), .crc_done(b_done), .crc_err(b_err), .frame_err(b_ferr));

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] qa_d[$], qb_d[$], exp_d[$];
  logic        qa_e[$], qb_e[$], exp_e[$], qa_done[$], qb_done[$];
  int          a_ferr_cnt = 0;
  int          stab_err = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d = '0;
  logic        prev_e = 1'b0;

  // Observe transfers at the falling edge, where inputs and outputs are settled.
  always @(negedge clk_75m) begin
    if (ifa.m_valid && ifa.m_ready) begin
      qa_d.push_back(ifa.m_data);
      qa_e.push_back(ifa.m_eof);
    end
    if (a_done) qa_done.push_back(a_err);
    if (a_ferr) a_ferr_cnt++;
    if (prev_stall && (!ifa.m_valid || ifa.m_data != prev_d || ifa.m_eof != prev_e))
      stab_err++;
    prev_stall = ifa.m_valid && !ifa.m_ready;
    prev_d     = ifa.m_data;
    prev_e     = ifa.m_eof;
    if (ifb.m_valid && ifb.m_ready) begin
      qb_d.push_back(ifb.m_data);
      qb_e.push_back(ifb.m_eof);
    end
    if (b_done) qb_done.push_back(b_err);
  end

  always @(posedge clk_75m) begin
    #1;
    if (rnd_en) m_ready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_q();
    qa_d.delete(); qa_e.delete(); qa_done.delete();
    qb_d.delete(); qb_e.delete(); qb_done.delete();
    exp_d.delete(); exp_e.delete();
    a_ferr_cnt = 0;
  endtask

  // Bounded valid/ready send; the accepting edge has just passed on return.
  task automatic send(input logic [31:0] d, input logic sof, input logic eof);
    int t;
    logic rdy;
    t = 0;
    s_valid = 1'b1; s_data = d; s_sof = sof; s_eof = eof;
    forever begin
      @(negedge clk_75m);
      rdy = sel ? ifb.s_ready : ifa.s_ready;
      if (rdy) break;
      t++;
      if (t > 100) begin
        n_cmp++; n_bad++;
        $display("FAIL send timeout: s_ready stuck low for data %h", d);
        break;
      end
    end
    @(posedge clk_75m); #1;
    s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk_75m);
    #1;
  endtask

  task automatic check_stream(input string nm, input logic use_b);
    int na;
    na = use_b ? qb_d.size() : qa_d.size();
    check({nm, " count"}, 32'(na), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < na; i++) begin
      check($sformatf("%s data%0d", nm, i), use_b ? qb_d[i] : qa_d[i], exp_d[i]);
      check($sformatf("%s eof%0d", nm, i), 32'(use_b ? qb_e[i] : qa_e[i]), 32'(exp_e[i]));
    end
  endtask

  // Bit-at-a-time MSB-first reference CRC.
  function automatic logic [31:0] model_crc(input logic [31:0] seed, input logic [31:0] d);
    logic [31:0] c;
    logic        fb;
    c = seed;
    for (int i = 31; i >= 0; i--) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ POLY;
    end
    return c;
  endfunction

  typedef struct {
    logic        rx;
    int          len;
    logic [31:0] d [3];
    logic [31:0] exp;   // TX: appended CRC; RX: expected crc_err
  } vec_t;

  vec_t tbl [12];

  task automatic set_vec(input int i, input logic rx, input int len, input logic [31:0] d0,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] exp);
    tbl[i].rx = rx; tbl[i].len = len;
    tbl[i].d[0] = d0; tbl[i].d[1] = d1; tbl[i].d[2] = d2;
    tbl[i].exp = exp;
  endtask

  initial begin
    logic [31:0] frame5 [5];
    logic [31:0] c;
    logic [31:0] loop_q[$];

    set_vec(0,  1'b0, 1, INIT,         32'h0,        32'h0,        32'h00000000);
    set_vec(1,  1'b0, 1, 32'h52325033, 32'h0,        32'h0,        32'h04C11DB7);
    set_vec(2,  1'b0, 1, 32'h52325030, 32'h0,        32'h0,        32'h09823B6E);
    set_vec(3,  1'b0, 2, INIT,         32'h00000001, 32'h0,        32'h04C11DB7);
    set_vec(4,  1'b0, 3, INIT,         32'h00000000, 32'h00000002, 32'h09823B6E);
    set_vec(5,  1'b0, 2, 32'h52325033, 32'h04C11DB7, 32'h0,        32'h00000000);
    set_vec(6,  1'b1, 2, INIT,         32'h00000000, 32'h0,        32'h0);
    set_vec(7,  1'b1, 2, INIT,         32'h00000001, 32'h0,        32'h1);
    set_vec(8,  1'b1, 2, 32'h52325033, 32'h04C11DB7, 32'h0,        32'h0);
    set_vec(9,  1'b1, 3, INIT,         32'h00000001, 32'h04C11DB7, 32'h0);
    set_vec(10, 1'b1, 3, INIT,         32'h00000001, 32'h04C11DB6, 32'h1);
    set_vec(11, 1'b1, 1, INIT,         32'h0,        32'h0,        32'h0);

    // Reset state while sys_rst is held.
    #12;
    check("rst s_ready", 32'(ifa.s_ready), 32'h0);
    check("rst m_valid", 32'(ifa.m_valid), 32'h0);
    check("rst m_data", ifa.m_data, 32'h0);
    check("rst crc_out", a_crc, INIT);
    check("rst crc_done", 32'(a_done), 32'h0);
    @(posedge clk_75m); #1;
    sys_rst = 1'b0;
    drain(2);

    // TX single-dword frame: one-cycle s_ready bubble for the CRC append.
    clear_q();
    mode_rx = 1'b0;
    send(INIT, 1'b1, 1'b1);
    @(negedge clk_75m);
    check("append s_ready low", 32'(ifa.s_ready), 32'h0);
    @(negedge clk_75m);
    check("append s_ready back", 32'(ifa.s_ready), 32'h1);
    drain(4);
    exp_d = '{INIT, 32'h0};
    exp_e = '{1'b0, 1'b1};
    check_stream("tx1", 1'b0);
    check("tx1 crc_out reseeded", a_crc, INIT);

    // Table of short frames with hand-computed CRCs / verdicts.
    for (int i = 0; i < 12; i++) begin
      clear_q();
      mode_rx = tbl[i].rx;
      for (int j = 0; j < tbl[i].len; j++) begin
        send(tbl[i].d[j], j == 0, j == tbl[i].len - 1);
        exp_d.push_back(tbl[i].d[j]);
        exp_e.push_back(tbl[i].rx && (j == tbl[i].len - 1));
      end
      if (!tbl[i].rx) begin
        exp_d.push_back(tbl[i].exp);
        exp_e.push_back(1'b1);
      end
      drain(6);
      check_stream($sformatf("vec%0d", i), 1'b0);
      check($sformatf("vec%0d done count", i), 32'(qa_done.size()), tbl[i].rx ? 32'h1 : 32'h0);
      if (tbl[i].rx && qa_done.size() > 0)
        check($sformatf("vec%0d crc_err", i), 32'(qa_done[0]), tbl[i].exp);
    end

    // Dword without SOF while idle is dropped and flagged.
    clear_q();
    mode_rx = 1'b0;
    send(32'hDEADBEEF, 1'b0, 1'b0);
    drain(4);
    check("nosof frame_err pulses", 32'(a_ferr_cnt), 32'h1);
    check("nosof no output", 32'(qa_d.size()), 32'h0);
    check("nosof crc_out", a_crc, INIT);

    // TX 5-dword frame under random backpressure, then looped back through RX.
    clear_q();
    frame5 = '{32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF, 32'hFFFFFFFF, 32'h00000000};
    c = INIT;
    for (int i = 0; i < 5; i++) begin
      c = model_crc(c, frame5[i]);
      exp_d.push_back(frame5[i]);
      exp_e.push_back(1'b0);
    end
    exp_d.push_back(c);
    exp_e.push_back(1'b1);
    stab_err = 0;
    mode_rx = 1'b0;
    rnd_en = 1'b1;
    for (int i = 0; i < 5; i++) send(frame5[i], i == 0, i == 4);
    for (int t = 0; t < 200 && qa_d.size() < 6; t++) @(posedge clk_75m);
    rnd_en = 1'b0;
    @(posedge clk_75m); #2;
    m_ready = 1'b1;
    drain(4);
    check_stream("stall", 1'b0);
    check("stall hold stable", 32'(stab_err), 32'h0);
    loop_q = qa_d;
    clear_q();
    mode_rx = 1'b1;
    for (int i = 0; i < loop_q.size(); i++) send(loop_q[i], i == 0, i == loop_q.size() - 1);
    drain(6);
    check("loop done count", 32'(qa_done.size()), 32'h1);
    if (qa_done.size() > 0) check("loop crc_err", 32'(qa_done[0]), 32'h0);

    // Asynchronous reset between edges during the third dword of a TX frame.
    clear_q();
    mode_rx = 1'b0;
    send(32'h11111111, 1'b1, 1'b0);
    send(32'h22222222, 1'b0, 1'b0);
    s_valid = 1'b1; s_data = 32'h33333333;
    @(negedge clk_75m); #2;
    sys_rst = 1'b1;
    #1;
    check("arst m_valid", 32'(ifa.m_valid), 32'h0);
    check("arst m_data", ifa.m_data, 32'h0);
    check("arst m_eof", 32'(ifa.m_eof), 32'h0);
    check("arst s_ready", 32'(ifa.s_ready), 32'h0);
    check("arst crc_out", a_crc, INIT);
    s_valid = 1'b0;
    @(posedge clk_75m); #1;
    sys_rst = 1'b0;
    drain(1);
    clear_q();
    send(INIT, 1'b1, 1'b1);
    drain(5);
    exp_d = '{INIT, 32'h0};
    exp_e = '{1'b0, 1'b1};
    check_stream("post-rst", 1'b0);

    // RX_STRIP: CRC dword is consumed, EOF moves to the previous dword.
    clear_q();
    sel = 1'b1;
    mode_rx = 1'b1;
    send(INIT, 1'b1, 1'b0);
    send(32'h00000001, 1'b0, 1'b0);
    send(32'h04C11DB7, 1'b0, 1'b1);
    drain(5);
    exp_d = '{INIT, 32'h00000001};
    exp_e = '{1'b0, 1'b1};
    check_stream("strip", 1'b1);
    check("strip done count", 32'(qb_done.size()), 32'h1);
    if (qb_done.size() > 0) check("strip crc_err", 32'(qb_done[0]), 32'h0);
    sel = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sata_crc_engine.md
Name: sata_crc_engine

Overview:
- Parametrised, streaming successor to the link-layer dword CRC.
- Sits between the transport-layer FIS stream and the link-layer scrambler.
- TX mode: passes FIS dwords through and appends the computed CRC dword after the last data dword.
- RX mode: treats the final dword of a frame as the received CRC, checks it against the CRC computed over the preceding dwords, and reports pass/fail.
- Valid/ready handshake on both sides; registered output stage.

Parameters:
- DATA_W, 32: dword width; CRC width equals DATA_W (only 32 is supported for SATA; others are for reuse).
- CRC_INIT, 32'h52325032: seed loaded at start of frame.
- CRC_POLY, 32'h04C11DB7: generator polynomial, MSB-first, non-reflected.
- RX_STRIP, 0: 1 = the received CRC dword is not forwarded on the output (RX mode only).

Ports:
- clk_75m  in  1  link clock
- sys_rst  in  1  asynchronous, active-high reset
- mode_rx  in  1  0 = TX/generate, 1 = RX/check; sampled only at the SOF accept
- s_valid  in  1  input dword valid
- s_ready  out  1  engine can accept a dword
- s_data  in  DATA_W  input dword
- s_sof  in  1  first dword of frame
- s_eof  in  1  last dword of frame (in RX, the received CRC)
- m_valid  out  1  output dword valid
- m_ready  in  1  downstream accepts
- m_data  out  DATA_W  output dword
- m_eof  out  1  last output dword of frame
- crc_out  out  DATA_W  running CRC register
- crc_done  out  1  one-cycle pulse: RX check complete
- crc_err  out  1  one-cycle pulse with crc_done: mismatch
- frame_err  out  1  one-cycle pulse: protocol error (data outside a frame)

Behaviour:
- CRC math, per accepted data dword:
  - x = s_data ^ seed, where seed = CRC_INIT on an SOF dword, else crc_out.
  - next = x shifted 32 times MSB-first through the CRC_POLY LFSR with zero input: each step, if bit31 is set then (x<<1)^POLY, else x<<1.
  - Purely combinational within one cycle; crc_out updates on the accept edge.
- Reset, asynchronous, any time including mid-frame:
  - state = IDLE; crc_out = CRC_INIT.
  - m_valid, m_eof, crc_done, crc_err, frame_err = 0; m_data = 0; s_ready = 0 while sys_rst is asserted.
- A transfer happens on a clock edge with valid && ready. The output register holds m_data/m_eof stable while m_valid && !m_ready.
- s_ready = (state is IDLE or DATA) && (!m_valid || m_ready).
- State machine IDLE / DATA / APPEND:
  - IDLE:
    - Accepted dword with s_sof: latch mode_rx, seed from CRC_INIT.
    - If s_eof is also set: TX → APPEND; RX → check the dword against CRC_INIT, stay IDLE.
    - Otherwise → DATA.
    - Accepted dword without s_sof: dropped; frame_err pulses; crc_out unchanged.
  - DATA:
    - TX: every dword is folded into the CRC and forwarded. On s_eof → APPEND, with m_eof = 0 on that dword.
    - RX: non-EOF dwords are folded and forwarded. The EOF dword is not folded; it is compared with crc_out. crc_done pulses the next cycle, crc_err = (dword != crc_out). The dword is forwarded with m_eof = 1 unless RX_STRIP = 1, in which case m_eof is marked on the previous forwarded dword (held one stage). State → IDLE.
    - Accepted s_sof in DATA: frame restart; the dword is re-seeded from CRC_INIT, frame_err pulses, and the previous frame is abandoned with no CRC appended.
  - APPEND (TX only):
    - s_ready = 0; m_data = crc_out; m_eof = 1; m_valid = 1.
    - Transfer → IDLE, crc_out reset to CRC_INIT.
- Latency: one cycle from input accept to m_valid. Throughput: 1 dword/clk with m_ready high; TX costs one bubble per frame for APPEND.
- mode_rx changes mid-frame are ignored.

Test Plan:
- TX single-dword frame s_data = 32'h52325032 (sof + eof), m_ready = 1 → output 32'h52325032, then 32'h00000000 with m_eof = 1; s_ready low exactly one cycle.
- RX frame {32'h52325032 sof, 32'h00000000 eof} → crc_done = 1, crc_err = 0. Repeat with eof dword 32'h00000001 → crc_done = 1, crc_err = 1.
- TX 5-dword frame, CRC compared against a bit-serial software model, with m_ready toggling pseudo-randomly → no dword lost or duplicated, m_data stable while stalled, CRC dword matches the model. Loop the TX output into RX → crc_err = 0.
- Dword with s_valid = 1 and no sof in IDLE → frame_err pulse, no m_valid, crc_out = 32'h52325032.
- Assert sys_rst asynchronously (between edges) during the 3rd dword of a TX frame → all outputs clear immediately. The next frame (sof 32'h52325032, eof) produces CRC 32'h00000000.
- RX_STRIP = 1, RX 3-dword frame → exactly 2 dwords output, m_eof on the 2nd, crc_done after the 3rd is accepted.
